// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks (TX now, RX later).
package uart_pkg;

    // Transmitter FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Parity selection values used by the PARITY parameter.
    typedef enum int {
        PAR_NONE = 0,
        PAR_ODD  = 1,
        PAR_EVEN = 2
    } parity_t;

    // Clock cycles per bit; integer division truncates toward zero.
    function automatic int calc_div(input int freq, input int speed);
        return freq / speed;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count. A push while full and a pop while
// empty are ignored, so callers can drive raw requests.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         Push,
    input  logic [WIDTH-1:0]             Push_Data,
    input  logic                         Pop,
    output logic [WIDTH-1:0]             Pop_Data,
    output logic                         Full,
    output logic                         Empty,
    output logic [$clog2(DEPTH+1)-1:0]   Level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged before any same-cycle pop, so a write while full is
    // always dropped even if space opens on that edge.
    assign Full     = (level_q == LW'(DEPTH));
    assign Empty    = (level_q == '0);
    assign Level    = level_q;
    assign Pop_Data = mem_q[rd_ptr_q];
    assign push_ok  = Push && !Full;
    assign pop_ok   = Pop && !Empty;

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all queued data.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge Clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= Push_Data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format fed by an input FIFO.
// Frames are sent back-to-back while the FIFO holds data.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | line high, waiting for the FIFO to become non-empty
//   ST_START   | start bit (low) for one bit time
//   ST_DATA    | DATA_BITS data bits, LSB first
//   ST_PARITY  | parity bit, only when PARITY != PAR_NONE
//   ST_STOP    | STOP_BITS stop bits (high); EOT on the last cycle
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FREQ_CLK   = 100000000,
    parameter int TX_SPEED   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              Clk,
    input  logic                              Rst_n,
    input  logic                              Wr_En,
    input  logic [DATA_BITS-1:0]              Wr_Data,
    output logic                              Full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   Level,
    output logic                              Busy,
    output logic                              EOT,
    output logic                              TX
);

    localparam int DIV     = calc_div(FREQ_CLK, TX_SPEED);
    localparam int CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BIT_W   = 4;
    localparam bit HAS_PAR = (PARITY != PAR_NONE);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: FREQ_CLK/TX_SPEED must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q;
    logic                 busy_q;
    logic                 eot_q;

    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 tick;
    logic                 last_data;
    logic                 last_stop;
    logic                 frame_end;

    // Odd parity makes the total count of ones odd, hence the XNOR.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_EVEN) ? ^d : ~^d;
    endfunction

    function automatic logic tx_decode(input state_t st, input logic lsb, input logic par);
        case (st)
            ST_START:  return 1'b0;
            ST_DATA:   return lsb;
            ST_PARITY: return par;
            default:   return 1'b1;
        endcase
    endfunction

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Push      (Wr_En),
        .Push_Data (Wr_Data),
        .Pop       (fifo_pop),
        .Pop_Data  (fifo_data),
        .Full      (Full),
        .Empty     (fifo_empty),
        .Level     (Level)
    );

    assign tick      = (cnt_q == CNT_W'(DIV - 1));
    assign last_data = (bit_q == BIT_W'(DATA_BITS - 1));
    assign last_stop = (bit_q == BIT_W'(STOP_BITS - 1));
    assign frame_end = (state_q == ST_STOP) && tick && last_stop;
    assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

    // Next-state logic: bit period counter, bit counter, shifter and parity.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q != ST_IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    shift_d = fifo_data;
                    par_d   = calc_parity(fifo_data);
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (last_data) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            state_d = ST_START;
                            shift_d = fifo_data;
                            par_d   = calc_parity(fifo_data);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // FSM registers; outputs are decoded from the next state so TX comes
    // straight from a flop (glitch-free) without adding a cycle of latency.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            eot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_decode(state_d, shift_d[0], par_d);
            busy_q  <= (state_d != ST_IDLE);
            eot_q   <= (state_d == ST_STOP) && (cnt_d == CNT_W'(DIV - 1))
                       && (bit_d == BIT_W'(STOP_BITS - 1));
        end
    end

    assign TX   = tx_q;
    assign Busy = busy_q;
    assign EOT  = eot_q;

endmodule
